// File: rtl/flash_audio_player.sv
// flash_audio_player: streams packed PCM words from an Avalon-MM flash read port to the
// audio path at a keyboard-adjustable sample rate.
// Build option FLASH_PLAYER_LOOP_EN: wrap to the opposite end of the clip instead of halting.
module flash_audio_player #(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned END_ADDR    = 'h7FFFF,
  parameter int unsigned DIV_DEFAULT = 2272,
  parameter int unsigned DIV_STEP    = 128,
  parameter int unsigned DIV_MIN     = 568,
  parameter int unsigned DIV_MAX     = 9088
) (
  input  logic                CLK_50M,
  input  logic                RESET_N,
  input  logic [7:0]          kbd_received_ascii_code,
  input  logic                kbd_data_ready,
  input  logic                flash_mem_waitrequest,
  input  logic                flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                playing,
  output logic                direction,
  output logic                underrun
);
  localparam int unsigned N      = DATA_W / SAMPLE_W;
  localparam int unsigned LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DIV_W  = $clog2(DIV_MAX + 1);

  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(END_ADDR);
  localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(N - 1);
  localparam logic [DIV_W-1:0]  DIV_DEF    = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0]  DIV_LO     = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0]  DIV_HI     = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0]  DIV_ST     = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0]  UP_LIM     = DIV_W'(DIV_MIN + DIV_STEP);
  localparam logic [DIV_W-1:0]  DN_LIM     = DIV_W'(DIV_MAX - DIV_STEP);

  typedef enum logic [2:0] {StIdle, StReq, StWaitData, StPlay, StNext} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;        // play pointer
  logic [ADDR_W-1:0]    fetch_addr_q, fetch_addr_d; // held stable while a read is pending
  logic [DATA_W-1:0]    word_q, word_d;
  logic                 word_fwd_q, word_fwd_d; // lane order of the buffered word
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 playing_q, playing_d;
  logic                 dir_q, dir_d;
  logic                 halted_q, halted_d;    // stopped at clip end, E locked out
  logic                 discard_q, discard_d;  // outstanding response belongs to a restart
  logic                 underrun_q, underrun_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     div_cur_q;             // divider of the period in progress
  logic [DIV_W-1:0]     cnt_q;
  logic                 kbd_prev_q;

  logic                 kbd_edge, tick, at_end;
  logic [7:0]           key;
  logic [LANE_W-1:0]    lane_idx;
  logic [SAMPLE_W-1:0]  lane_sample;
  logic [ADDR_W-1:0]    addr_step;
  logic cmd_play, cmd_pause, cmd_fwd, cmd_back, cmd_restart, cmd_up, cmd_down, cmd_norm;

  // Folding bit 5 maps upper-case letters onto lower-case ones.
  assign kbd_edge    = kbd_data_ready & ~kbd_prev_q;
  assign key         = kbd_received_ascii_code | 8'h20;
  assign cmd_play    = kbd_edge && (key == 8'h65);
  assign cmd_pause   = kbd_edge && (key == 8'h64);
  assign cmd_fwd     = kbd_edge && (key == 8'h66);
  assign cmd_back    = kbd_edge && (key == 8'h62);
  assign cmd_restart = kbd_edge && (key == 8'h72);
  assign cmd_up      = kbd_edge && (key == 8'h75);
  assign cmd_down    = kbd_edge && (key == 8'h6c);
  assign cmd_norm    = kbd_edge && (key == 8'h6e);

  assign tick        = playing_q && (cnt_q == div_cur_q);
  assign lane_idx    = word_fwd_q ? lane_q : LANE_LAST - lane_q;
  assign lane_sample = word_q[SAMPLE_W*int'(lane_idx) +: SAMPLE_W];
  assign at_end      = dir_q ? (addr_q == ADDR_LAST) : (addr_q == ADDR_FIRST);
  assign addr_step   = dir_q ? addr_q + 1'b1 : addr_q - 1'b1;

  // Sample-rate counter; a new divider is picked up only at reload.
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      div_cur_q <= DIV_DEF;
    end else if (!playing_q || tick) begin
      cnt_q     <= '0;
      div_cur_q <= div_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fetch/playback next state; commands are applied after the tick so a coincident tick
  // still runs under the old settings.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fetch_addr_d = fetch_addr_q;
    word_d       = word_q;
    word_fwd_d   = word_fwd_q;
    lane_d       = lane_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    playing_d    = playing_q;
    dir_d        = dir_q;
    halted_d     = halted_q;
    discard_d    = discard_q;
    underrun_d   = underrun_q;
    div_d        = div_q;

    if (tick && (state_q != StPlay)) underrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (playing_q) begin
          state_d      = StReq;
          fetch_addr_d = addr_q;
        end
      end
      StReq: begin
        if (!flash_mem_waitrequest) state_d = StWaitData;
      end
      StWaitData: begin
        if (flash_mem_readdatavalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            word_d     = flash_mem_readdata;
            word_fwd_d = dir_q;
            lane_d     = '0;
            state_d    = StPlay;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          sample_d = lane_sample;
          valid_d  = 1'b1;
          if (lane_q == LANE_LAST) begin
            lane_d  = '0;
            state_d = StNext;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StNext: begin
        if (at_end) begin
`ifdef FLASH_PLAYER_LOOP_EN
          addr_d       = dir_q ? ADDR_FIRST : ADDR_LAST;
          fetch_addr_d = dir_q ? ADDR_FIRST : ADDR_LAST;
          state_d      = StReq;
`else
          playing_d = 1'b0;
          halted_d  = 1'b1;
          state_d   = StIdle;
`endif
        end else begin
          addr_d       = addr_step;
          fetch_addr_d = addr_step;
          state_d      = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cmd_play && !halted_q) playing_d = 1'b1;
    if (cmd_pause) playing_d = 1'b0;
    if (cmd_fwd) begin
      dir_d = 1'b1;
      if (!dir_q) halted_d = 1'b0;
    end
    if (cmd_back) begin
      dir_d = 1'b0;
      if (dir_q) halted_d = 1'b0;
    end
    if (cmd_up) div_d = (div_q < UP_LIM) ? DIV_LO : div_q - DIV_ST;
    if (cmd_down) div_d = (div_q > DN_LIM) ? DIV_HI : div_q + DIV_ST;
    if (cmd_norm) div_d = DIV_DEF;
    if (cmd_restart) begin
      addr_d     = dir_q ? ADDR_FIRST : ADDR_LAST;
      lane_d     = '0;
      underrun_d = 1'b0;
      playing_d  = 1'b1;
      halted_d   = 1'b0;
      // A read still in flight must complete; its data is dropped.
      if ((state_q == StReq) || ((state_q == StWaitData) && !flash_mem_readdatavalid)) begin
        discard_d = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      addr_q       <= ADDR_FIRST;
      fetch_addr_q <= ADDR_FIRST;
      word_q       <= '0;
      word_fwd_q   <= 1'b1;
      lane_q       <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      playing_q    <= 1'b0;
      dir_q        <= 1'b1;
      halted_q     <= 1'b0;
      discard_q    <= 1'b0;
      underrun_q   <= 1'b0;
      div_q        <= DIV_DEF;
      kbd_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fetch_addr_q <= fetch_addr_d;
      word_q       <= word_d;
      word_fwd_q   <= word_fwd_d;
      lane_q       <= lane_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      playing_q    <= playing_d;
      dir_q        <= dir_d;
      halted_q     <= halted_d;
      discard_q    <= discard_d;
      underrun_q   <= underrun_d;
      div_q        <= div_d;
      kbd_prev_q   <= kbd_data_ready;
    end
  end

  assign flash_mem_read    = (state_q == StReq);
  assign flash_mem_address = fetch_addr_q;
  assign audio_data        = playing_q ? sample_q : '0;
  assign audio_valid       = valid_q;
  assign playing           = playing_q;
  assign direction         = dir_q;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_flash_audio_player.sv
// Scoreboard bench for flash_audio_player: expected read addresses and audio samples are
// queued as stimulus is applied and popped as the DUT issues reads / pulses audio_valid.
module tb_flash_audio_player;
  localparam int unsigned END_A = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  kbd_code;
  logic        kbd_rdy;
  logic        waitreq = 1'b0;
  logic        rdv = 1'b0;
  logic [31:0] rdata = '0;
  logic        read;
  logic [22:0] addr;
  logic [15:0] audio;
  logic        aval;
  logic        playing;
  logic        direction;
  logic        underrun;

  logic        wait_hold = 1'b0;
  logic        poison = 1'b0;
  int          rsp_lat = 2;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;

  logic [15:0] exp_audio[$];
  logic [22:0] exp_addr[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  int          cyc = 0;

  flash_audio_player #(
    .END_ADDR(END_A)
  ) dut (
    .CLK_50M                 (clk),
    .RESET_N                 (rst_n),
    .kbd_received_ascii_code (kbd_code),
    .kbd_data_ready          (kbd_rdy),
    .flash_mem_waitrequest   (waitreq),
    .flash_mem_readdatavalid (rdv),
    .flash_mem_readdata      (rdata),
    .flash_mem_read          (read),
    .flash_mem_address       (addr),
    .audio_data              (audio),
    .audio_valid             (aval),
    .playing                 (playing),
    .direction               (direction),
    .underrun                (underrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [22:0] a);
    logic [15:0] lo;
    if (a == 23'd0) return 32'hBBBB_AAAA;
    if (a == 23'(END_A)) return 32'h2222_1111;
    lo = 16'hC000 + {a[14:0], 1'b0};
    return {lo + 16'd1, lo};
  endfunction

  // Flash model: accepts a read when read is high and waitrequest low, answers after rsp_lat.
  always @(negedge clk) begin
    waitreq = wait_hold;
    rdv = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        rdv   = 1'b1;
        rdata = pend_data;
        pend  = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (read && !waitreq) begin
      if (exp_addr.size() == 0) check_eq("read_extra", 32'(exp_addr.size()), 1);
      else check_eq("read_addr", addr, exp_addr.pop_front());
      pend      = 1'b1;
      pend_cnt  = rsp_lat;
      pend_data = poison ? 32'hDEAD_DEAD : word_of(addr);
    end
  end

  // Audio scoreboard.
  always @(negedge clk) begin
    if (aval) begin
      if (exp_audio.size() == 0) check_eq("audio_extra", 32'(exp_audio.size()), 1);
      else check_eq("audio", audio, exp_audio.pop_front());
      n_valid++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] ch);
    @(negedge clk);
    kbd_code = ch;
    kbd_rdy  = 1'b1;
    @(negedge clk);
    kbd_rdy  = 1'b0;
  endtask

  task automatic wait_sample(input string tag, output int c);
    logic found;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (aval) begin
        found = 1'b1;
        c = cyc;
        break;
      end
    end
    check_eq({"seen_", tag}, found, 1);
  endtask

  initial begin
    int c1, c2, c3, c4, bad, n0;
    logic found;
    rst_n    = 1'b0;
    kbd_code = 8'h00;
    kbd_rdy  = 1'b0;
    idle(4);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_direction", direction, 1);
    check_eq("rst_read", read, 0);
    check_eq("rst_address", addr, 0);
    check_eq("rst_audio", audio, 0);
    check_eq("rst_valid", aval, 0);
    check_eq("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    idle(2);

    // Forward playback of word 0 at the default rate.
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    exp_audio.push_back(16'hAAAA);
    exp_audio.push_back(16'hBBBB);
    press("e");
    check_eq("play_on", playing, 1);
    wait_sample("s1a", c1);
    wait_sample("s1b", c2);
    check_eq("period_default", 32'(c2 - c1), 2273);
    idle(20);

    // Backward from END_ADDR down to START_ADDR.
    exp_addr.push_back(23'd3);
    exp_addr.push_back(23'd2);
    exp_addr.push_back(23'd1);
    exp_addr.push_back(23'd0);
`ifdef FLASH_PLAYER_LOOP_EN
    exp_addr.push_back(23'd3);
`endif
    exp_audio.push_back(16'h2222);
    exp_audio.push_back(16'h1111);
    exp_audio.push_back(16'hC005);
    exp_audio.push_back(16'hC004);
    exp_audio.push_back(16'hC003);
    exp_audio.push_back(16'hC002);
    exp_audio.push_back(16'hBBBB);
    exp_audio.push_back(16'hAAAA);
    press("B");
    press("r");
    check_eq("dir_back", direction, 0);
    check_eq("restart_playing", playing, 1);
    wait_sample("s2a", c1);
    wait_sample("s2b", c2);
    check_eq("period_back", 32'(c2 - c1), 2273);

    // Speed up past the limit.
    repeat (20) press("u");
    wait_sample("s3a", c3);
    wait_sample("s3b", c4);
    check_eq("period_fast", 32'(c4 - c3), 569);
    wait_sample("s3c", c1);
    wait_sample("s3d", c2);
    check_eq("period_fast2", 32'(c2 - c1), 569);
    wait_sample("s3e", c1);
    wait_sample("s3f", c2);
    idle(10);
`ifdef FLASH_PLAYER_LOOP_EN
    check_eq("loop_playing", playing, 1);
    check_eq("loop_read_done", 32'(exp_addr.size()), 0);
    press("d");
    check_eq("pause_playing", playing, 0);
`else
    check_eq("end_playing", playing, 0);
    check_eq("end_audio", audio, 0);
    check_eq("end_read", read, 0);
    check_eq("end_address", addr, 0);
    press("E");
    check_eq("end_e_locked", playing, 0);
`endif

    // Long waitrequest: request must stay put while ticks underrun.
    wait_hold = 1'b1;
    press("F");
    press("R");
    exp_addr.push_back(23'd0);
    idle(3);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (read !== 1'b1 || addr !== 23'd0) bad++;
    end
    check_eq("wait_stable", bad, 0);
    check_eq("underrun_set", underrun, 1);
    check_eq("audio_hold", audio, 16'hAAAA);

    // Restart while the response is outstanding: stale data must be dropped.
    poison    = 1'b1;
    rsp_lat   = 50;
    wait_hold = 1'b0;
    idle(3);
    poison  = 1'b0;
    rsp_lat = 2;
    check_eq("in_wait_data", read, 0);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    exp_audio.push_back(16'hAAAA);
    exp_audio.push_back(16'hBBBB);
    press("R");
    check_eq("underrun_clear", underrun, 0);
    bad = 0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdv) begin
        found = 1'b1;
        break;
      end
      if (read) bad++;
    end
    check_eq("stale_rsp_seen", found, 1);
    check_eq("no_early_read", bad, 0);

    // Pause mid-word, then resume from the same lane.
    wait_sample("s5a", c1);
    press("d");
    check_eq("pause_audio", audio, 0);
    n0 = n_valid;
    idle(1500);
    check_eq("pause_no_valid", 32'(n_valid - n0), 0);
    press("E");
    wait_sample("s5b", c2);
    idle(20);
    check_eq("audio_left", 32'(exp_audio.size()), 0);
    check_eq("addr_left", 32'(exp_addr.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
